// File: rtl/dsm_pkg.sv
// Shared types and constants for the delta-sigma output averager and its modulator bench.
package dsm_pkg;

  localparam int DSM_IN_W = 4;
  localparam int FRAC_W   = 16;

  localparam logic [DSM_IN_W-1:0] DSM_MIN_LEGAL = 4'd5;
  localparam logic [DSM_IN_W-1:0] DSM_MAX_LEGAL = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_ACCUM,
    ST_DONE
  } dsm_state_t;

  typedef struct packed {
    logic [DSM_IN_W-1:0] avg_i;
    logic [FRAC_W-1:0]   avg_f;
    logic                range_err;
  } dsm_result_t;

endpackage

// File: rtl/dsm_avg_decoder.sv
// Recovers the mean of a DSM divide stream over 2^WIN_LOG2 samples after SKIP discarded ones.
// Result one cycle after the last sample; no backpressure, in_valid-low cycles simply stall counting.
module dsm_avg_decoder
  import dsm_pkg::*;
#(
  parameter int                  WIN_LOG2  = 16,
  parameter int                  SKIP      = 4,
  parameter logic [DSM_IN_W-1:0] MIN_LEGAL = DSM_MIN_LEGAL,
  parameter logic [DSM_IN_W-1:0] MAX_LEGAL = DSM_MAX_LEGAL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DSM_IN_W-1:0] dsm_in,
  input  logic                in_valid,
  input  logic                start,
  output logic                busy,
  output logic                result_valid,
  output logic [DSM_IN_W-1:0] avg_i,
  output logic [FRAC_W-1:0]   avg_f,
  output logic                range_err
);

  localparam int SUM_W = WIN_LOG2 + DSM_IN_W;
  localparam int EXT_W = (WIN_LOG2 > FRAC_W) ? WIN_LOG2 : FRAC_W;
  localparam logic [WIN_LOG2:0] WIN_LAST  = {1'b0, {WIN_LOG2{1'b1}}};
  localparam logic [7:0]        SKIP_LAST = 8'((SKIP > 0) ? SKIP - 1 : 0);
  localparam dsm_state_t        FIRST_ST  = (SKIP > 0) ? ST_SKIP : ST_ACCUM;

  dsm_state_t        state, state_nx;
  logic [SUM_W-1:0]  sum, sum_nx;
  logic [WIN_LOG2:0] win_cnt;
  logic [7:0]        skip_cnt;
  logic              err_acc;
  logic              bad, skip_end, win_end;
  logic [EXT_W-1:0]  frac_ext;
  logic [FRAC_W-1:0] frac_nx;

  assign bad      = (dsm_in < MIN_LEGAL) || (dsm_in > MAX_LEGAL);
  assign sum_nx   = sum + SUM_W'(dsm_in);
  assign skip_end = (state == ST_SKIP) && in_valid && (skip_cnt == SKIP_LAST);
  assign win_end  = (state == ST_ACCUM) && in_valid && (win_cnt == WIN_LAST);

  // Fraction is the sum's low WIN_LOG2 bits scaled to 16 bits: truncate wide windows, pad narrow ones.
  assign frac_ext = EXT_W'(sum_nx[WIN_LOG2-1:0]);
  generate
    if (WIN_LOG2 >= FRAC_W) begin : g_frac_trunc
      assign frac_nx = FRAC_W'(frac_ext >> (WIN_LOG2 - FRAC_W));
    end else begin : g_frac_pad
      assign frac_nx = FRAC_W'(frac_ext << (FRAC_W - WIN_LOG2));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // start restarts from any state, including the final-sample cycle, which drops that result.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = FIRST_ST;
    end else begin
      case (state)
        ST_IDLE:  state_nx = ST_IDLE;
        ST_SKIP:  if (skip_end) state_nx = ST_ACCUM;
        ST_ACCUM: if (win_end)  state_nx = ST_DONE;
        ST_DONE:  state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state == ST_SKIP) || (state == ST_ACCUM);
    result_valid = (state == ST_DONE);
  end

  // Result registers load on the final sample so they are already valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      win_cnt   <= '0;
      skip_cnt  <= '0;
      err_acc   <= 1'b0;
      avg_i     <= '0;
      avg_f     <= '0;
      range_err <= 1'b0;
    end else if (start) begin
      sum      <= '0;
      win_cnt  <= '0;
      skip_cnt <= '0;
      err_acc  <= 1'b0;
    end else begin
      if ((state == ST_SKIP) && in_valid) skip_cnt <= skip_cnt + 8'd1;
      if ((state == ST_ACCUM) && in_valid) begin
        sum     <= sum_nx;
        win_cnt <= win_cnt + 1'b1;
        err_acc <= err_acc | bad;
      end
      if (win_end) begin
        avg_i     <= sum_nx[SUM_W-1 -: DSM_IN_W];
        avg_f     <= frac_nx;
        range_err <= err_acc | bad;
      end
    end
  end

endmodule

// File: tb/tb_dsm_avg_decoder.sv
// Scoreboard bench for dsm_avg_decoder at three parameter points (W=4/SKIP=0, W=4/SKIP=2, W=16/SKIP=4).
module tb_dsm_avg_decoder;
  import dsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  dsm_in = 4'd0;
  logic        in_valid = 1'b0;
  logic        start0 = 1'b0, start2 = 1'b0, start16 = 1'b0;

  logic        busy0, rv0, re0, busy2, rv2, re2, busy16, rv16, re16;
  logic [3:0]  ai0, ai2, ai16;
  logic [15:0] af0, af2, af16;

  dsm_result_t q0[$], q2[$], q16[$];
  dsm_result_t e0, e2, e16;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dsm_avg_decoder #(.WIN_LOG2(4), .SKIP(0)) u0 (
    .clk(clk), .rst(rst), .dsm_in(dsm_in), .in_valid(in_valid), .start(start0),
    .busy(busy0), .result_valid(rv0), .avg_i(ai0), .avg_f(af0), .range_err(re0));

  dsm_avg_decoder #(.WIN_LOG2(4), .SKIP(2)) u2 (
    .clk(clk), .rst(rst), .dsm_in(dsm_in), .in_valid(in_valid), .start(start2),
    .busy(busy2), .result_valid(rv2), .avg_i(ai2), .avg_f(af2), .range_err(re2));

  dsm_avg_decoder #(.WIN_LOG2(16), .SKIP(4)) u16 (
    .clk(clk), .rst(rst), .dsm_in(dsm_in), .in_valid(in_valid), .start(start16),
    .busy(busy16), .result_valid(rv16), .avg_i(ai16), .avg_f(af16), .range_err(re16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: result_valid with no expected result queued", name);
  endtask

  // Monitors: every result_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rv0) begin
      if (q0.size() == 0) unexpected("u0_result");
      else begin
        e0 = q0.pop_front();
        check("u0_result", {11'd0, ai0, af0, re0}, {11'd0, e0});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rv2) begin
      if (q2.size() == 0) unexpected("u2_result");
      else begin
        e2 = q2.pop_front();
        check("u2_result", {11'd0, ai2, af2, re2}, {11'd0, e2});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rv16) begin
      if (q16.size() == 0) unexpected("u16_result");
      else begin
        e16 = q16.pop_front();
        check("u16_result", {11'd0, ai16, af16, re16}, {11'd0, e16});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] v);
    dsm_in   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] gap_mask;
  logic        busy_ok;
  logic [16:0] mod_acc;

  initial begin
    // Reset state
    tick();
    tick();
    check("reset_u0_outputs", {9'd0, busy0, rv0, ai0, af0, re0}, 32'd0);
    check("reset_u16_busy", {31'd0, busy16}, 32'd0);
    rst = 1'b0;
    tick();

    // Constant 7, no skip: result on the 17th cycle after the first sample
    start0 = 1'b1; tick(); start0 = 1'b0;
    q0.push_back(dsm_result_t'{avg_i: 4'd7, avg_f: 16'h0000, range_err: 1'b0});
    for (int k = 0; k < 16; k++) put(4'd7);
    check("t1_rv_latency", {31'd0, rv0}, 32'd1);
    check("t1_busy_in_done", {31'd0, busy0}, 32'd0);
    tick();
    check("t1_rv_one_cycle", {31'd0, rv0}, 32'd0);
    check("t1_hold_avg_i", {28'd0, ai0}, 32'd7);

    // SKIP=2: two 12s discarded, then 8/9 alternating -> 8.5
    start2 = 1'b1; tick(); start2 = 1'b0;
    put(4'd12);
    put(4'd12);
    check("t2_busy_after_skip", {31'd0, busy2}, 32'd1);
    q2.push_back(dsm_result_t'{avg_i: 4'd8, avg_f: 16'h8000, range_err: 1'b0});
    busy_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      put((k % 2) ? 4'd9 : 4'd8);
      if (k < 15 && busy2 !== 1'b1) busy_ok = 1'b0;
    end
    check("t2_busy_whole_window", {31'd0, busy_ok}, 32'd1);
    check("t2_rv", {31'd0, rv2}, 32'd1);
    tick();

    // 15x6 + one 13 (out of range), three in_valid gaps carrying junk: sum 103
    gap_mask = 16'd0;
    while ($countones(gap_mask) != 3) gap_mask[$urandom_range(15, 0)] = 1'b1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    q0.push_back(dsm_result_t'{avg_i: 4'd6, avg_f: 16'h7000, range_err: 1'b1});
    for (int k = 0; k < 16; k++) begin
      if (gap_mask[k]) begin
        dsm_in = 4'd15; in_valid = 1'b0; tick();
      end
      put((k == 9) ? 4'd13 : 4'd6);
    end
    for (int k = 0; k < 4; k++) tick();

    // Restart mid-window: only the second window reports
    start0 = 1'b1; tick(); start0 = 1'b0;
    for (int k = 0; k < 10; k++) put(4'd5);
    start0 = 1'b1; tick(); start0 = 1'b0;
    q0.push_back(dsm_result_t'{avg_i: 4'd10, avg_f: 16'h0000, range_err: 1'b0});
    for (int k = 0; k < 16; k++) put(4'd10);
    tick();
    tick();

    // start keeps the held result; rst mid-window clears everything
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("t4_hold_after_start", {28'd0, ai0}, 32'd10);
    for (int k = 0; k < 5; k++) put(4'd9);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t4_rst_outputs", {9'd0, busy0, rv0, ai0, af0, re0}, 32'd0);
    for (int k = 0; k < 20; k++) put(4'd9);
    check("t4_idle_after_rst", {31'd0, busy0}, 32'd0);

    // start on the final sample: no result, fresh window
    start0 = 1'b1; tick(); start0 = 1'b0;
    for (int k = 0; k < 15; k++) put(4'd7);
    dsm_in = 4'd7; in_valid = 1'b1; start0 = 1'b1;
    tick();
    in_valid = 1'b0; start0 = 1'b0;
    check("t5_no_rv_on_restart", {31'd0, rv0}, 32'd0);
    check("t5_busy_on_restart", {31'd0, busy0}, 32'd1);
    q0.push_back(dsm_result_t'{avg_i: 4'd11, avg_f: 16'h0000, range_err: 1'b0});
    for (int k = 0; k < 16; k++) put(4'd11);
    check("t5_rv_fresh_window", {31'd0, rv0}, 32'd1);
    // start during DONE: result already loaded, next window begins
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("t5_busy_after_done_start", {31'd0, busy0}, 32'd1);
    check("t5_result_kept", {28'd0, ai0}, 32'd11);
    q0.push_back(dsm_result_t'{avg_i: 4'd5, avg_f: 16'h0000, range_err: 1'b0});
    for (int k = 0; k < 16; k++) put(4'd5);
    check("t5_rv_second", {31'd0, rv0}, 32'd1);
    tick();

    // First-order modulator at 8 + 0x4000/65536: window of 65536 holds exactly 16384 carries
    start16 = 1'b1; tick(); start16 = 1'b0;
    q16.push_back(dsm_result_t'{avg_i: 4'd8, avg_f: 16'h4000, range_err: 1'b0});
    mod_acc = 17'd0;
    for (int n = 0; n < 65536 + 4; n++) begin
      mod_acc = {1'b0, mod_acc[15:0]} + 17'h04000;
      put(4'd8 + {3'd0, mod_acc[16]});
    end
    check("t6_rv", {31'd0, rv16}, 32'd1);
    tick();
    tick();

    check("q0_drained", q0.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    check("q16_drained", q16.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
